// File: rtl/io_port_pkg.sv
// Shared constants and types for the memory-mapped I/O port controller.
package io_port_pkg;

   localparam int BYTE_W = 8;
   localparam int CNT_W  = 32;

   // Address decode: upper select bits and low offsets within the I/O window
   localparam logic [1:0] IO_BASE_SEL = 2'b11;
   localparam logic [2:0] OFF_UART    = 3'd0;
   localparam logic [2:0] OFF_CLK     = 3'd4;

   // TX FIFO entry: the terminator flag travels with the 0x00 stop byte
   typedef struct packed {
      logic              term;
      logic [BYTE_W-1:0] data;
   } tx_entry_t;

   // Pick byte idx (0..3) out of a 32-bit word
   function automatic logic [BYTE_W-1:0] snap_byte(input logic [CNT_W-1:0] v,
                                                   input logic [1:0] idx);
      return v[{idx, 3'b000} +: BYTE_W];
   endfunction

endpackage

// File: rtl/io_port_ctrl_if.sv
// Core-side external bus as seen by the I/O controller.
interface io_port_ctrl_if;
   import io_port_pkg::*;

   logic              rdy_in;
   logic [31:0]       cpu_a;
   logic [BYTE_W-1:0] cpu_dout;
   logic              cpu_wr;
   logic [BYTE_W-1:0] cpu_din;
   logic              io_sel;
   logic              io_buffer_full;

   modport master (output rdy_in, cpu_a, cpu_dout, cpu_wr,
                   input  cpu_din, io_sel, io_buffer_full);
   modport slave  (input  rdy_in, cpu_a, cpu_dout, cpu_wr,
                   output cpu_din, io_sel, io_buffer_full);
endinterface

// File: rtl/io_sync_fifo.sv
// Single-clock FIFO with occupancy count; a pop frees a slot for a same-cycle push.
module io_sync_fifo #(
   parameter int WIDTH     = 8,
   parameter int DEPTH_LOG = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 push,
   input  logic [WIDTH-1:0]     wdata,
   input  logic                 pop,
   output logic [WIDTH-1:0]     rdata,
   output logic                 empty,
   output logic                 full,
   output logic [DEPTH_LOG:0]   count
);
   localparam int DEPTH = 1 << DEPTH_LOG;
   localparam logic [DEPTH_LOG-1:0] PTR_ONE = 1;
   localparam logic [DEPTH_LOG:0]   CNT_ONE = 1;

   logic [WIDTH-1:0]     mem_q [DEPTH];
   logic [DEPTH_LOG-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG:0]   count_q, count_d;
   logic                 do_push, do_pop;

   assign empty = (count_q == '0);
   assign full  = count_q[DEPTH_LOG];
   assign count = count_q;
   assign rdata = mem_q[rd_ptr_q];

   // Accept/release decisions and next pointer/count values
   always_comb begin
      do_pop   = pop & ~empty;
      do_push  = push & (~full | do_pop);
      wr_ptr_d = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      rd_ptr_d = do_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
      count_d  = count_q;
      if (do_push && !do_pop)      count_d = count_q + CNT_ONE;
      else if (do_pop && !do_push) count_d = count_q - CNT_ONE;
   end

   // Pointer and count state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset; occupancy is tracked by count_q
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/io_port_ctrl.sv
// Memory-mapped I/O controller: UART TX/RX FIFOs, free-running cycle counter
// with coherent 32-bit readout, and program stop via a queued terminator byte.
module io_port_ctrl
   import io_port_pkg::*;
#(
   parameter int TX_DEPTH_LOG = 4,
   parameter int RX_DEPTH_LOG = 4,
   parameter int FULL_MARGIN  = 2
) (
   input  logic              clk_in,
   input  logic              rst_in,
   io_port_ctrl_if.slave     bus,
   output logic              tx_valid,
   output logic [BYTE_W-1:0] tx_data,
   input  logic              tx_ready,
   input  logic              rx_valid,
   input  logic [BYTE_W-1:0] rx_data,
   output logic              rx_ready,
   output logic              program_stop,
   output logic              tx_overflow
);
   localparam int TX_DEPTH = 1 << TX_DEPTH_LOG;
   localparam logic [CNT_W-1:0] CNT_ONE = 1;

   logic              hit, wr_hit, rd_hit;
   logic [2:0]        off;

   logic              tx_push, tx_pop, tx_empty, tx_full;
   tx_entry_t         tx_wdata, tx_head;
   logic [TX_DEPTH_LOG:0] tx_count;

   logic              rx_push, rx_pop, rx_empty, rx_full;
   logic [BYTE_W-1:0] rx_head;
   logic [RX_DEPTH_LOG:0] unused_rx_cnt;

   logic [CNT_W-1:0]  counter_q, counter_d, snapshot_q, snapshot_d;
   logic [BYTE_W-1:0] cpu_din_q, cpu_din_d;
   logic              io_sel_q, io_sel_d;
   logic              stopped_q, stopped_d;
   logic              tx_overflow_q, tx_overflow_d;
   logic              program_stop_q, program_stop_d;

   // Address bits outside the decode are don't-care
   logic unused_addr;
   assign unused_addr = ^{bus.cpu_a[31:18], bus.cpu_a[15:3]};

   assign hit    = bus.rdy_in & (bus.cpu_a[17:16] == IO_BASE_SEL);
   assign off    = bus.cpu_a[2:0];
   assign wr_hit = hit & bus.cpu_wr;
   assign rd_hit = hit & ~bus.cpu_wr;

   assign tx_valid = ~tx_empty;
   assign tx_data  = tx_head.data;
   assign tx_pop   = tx_valid & tx_ready;
   assign rx_ready = ~rx_full;
   assign rx_push  = rx_valid & rx_ready;

   assign bus.cpu_din        = cpu_din_q;
   assign bus.io_sel         = io_sel_q;
   assign bus.io_buffer_full = (TX_DEPTH - int'(tx_count)) <= FULL_MARGIN;
   assign program_stop       = program_stop_q;
   assign tx_overflow        = tx_overflow_q;

   // Write decode: UART bytes and the stop terminator feed the TX FIFO
   always_comb begin
      tx_push   = 1'b0;
      tx_wdata  = '0;
      stopped_d = stopped_q;
      if (wr_hit && !stopped_q) begin
         if (off == OFF_UART && bus.cpu_dout != '0) begin
            tx_push       = 1'b1;
            tx_wdata.data = bus.cpu_dout;
         end else if (off == OFF_CLK) begin
            tx_push       = 1'b1;
            tx_wdata.term = 1'b1;
            stopped_d     = 1'b1;
         end
      end
      // A full FIFO only drops the byte if nothing leaves this cycle
      tx_overflow_d  = tx_overflow_q | (tx_push & tx_full & ~tx_pop);
      program_stop_d = tx_pop & tx_head.term;
   end

   // Read decode: returned data is registered and presented next cycle
   always_comb begin
      cpu_din_d  = cpu_din_q;
      snapshot_d = snapshot_q;
      io_sel_d   = rd_hit;
      rx_pop     = 1'b0;
      counter_d  = counter_q + CNT_ONE;
      if (rd_hit) begin
         case (off)
            OFF_UART: begin
               cpu_din_d = rx_empty ? '0 : rx_head;
               rx_pop    = ~rx_empty;
            end
            // Low byte read freezes the full count so upper bytes stay coherent
            OFF_CLK: begin
               snapshot_d = counter_q;
               cpu_din_d  = counter_q[BYTE_W-1:0];
            end
            3'd5, 3'd6, 3'd7: cpu_din_d = snap_byte(snapshot_q, off[1:0]);
            default:          cpu_din_d = '0;
         endcase
      end
   end

   // Controller state registers
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         counter_q      <= '0;
         snapshot_q     <= '0;
         cpu_din_q      <= '0;
         io_sel_q       <= 1'b0;
         stopped_q      <= 1'b0;
         tx_overflow_q  <= 1'b0;
         program_stop_q <= 1'b0;
      end else begin
         counter_q      <= counter_d;
         snapshot_q     <= snapshot_d;
         cpu_din_q      <= cpu_din_d;
         io_sel_q       <= io_sel_d;
         stopped_q      <= stopped_d;
         tx_overflow_q  <= tx_overflow_d;
         program_stop_q <= program_stop_d;
      end
   end

   io_sync_fifo #(.WIDTH($bits(tx_entry_t)), .DEPTH_LOG(TX_DEPTH_LOG)) u_tx_fifo (
      .clk   (clk_in),
      .rst_n (rst_in),
      .push  (tx_push),
      .wdata (tx_wdata),
      .pop   (tx_pop),
      .rdata (tx_head),
      .empty (tx_empty),
      .full  (tx_full),
      .count (tx_count)
   );

   io_sync_fifo #(.WIDTH(BYTE_W), .DEPTH_LOG(RX_DEPTH_LOG)) u_rx_fifo (
      .clk   (clk_in),
      .rst_n (rst_in),
      .push  (rx_push),
      .wdata (rx_data),
      .pop   (rx_pop),
      .rdata (rx_head),
      .empty (rx_empty),
      .full  (rx_full),
      .count (unused_rx_cnt)
   );

endmodule

// File: doc/io_port_ctrl.md
Name: io_port_ctrl

Overview:
Memory-mapped I/O controller directly downstream of the CPU core's external bus (mem_a/mem_dout/mem_wr/mem_din). Decodes accesses with mem_a[17:16]==2'b11 and implements UART output (0x30000 write), UART input (0x30000 read), cycle counter (0x30004 read) and program stop (0x30004 write). Generates io_buffer_full back to the core. RAM accesses pass by untouched; the top level muxes read data using io_sel.

Parameters:
TX_DEPTH_LOG, 4, log2 of TX FIFO depth (16 bytes)
RX_DEPTH_LOG, 4, log2 of RX FIFO depth (16 bytes)
FULL_MARGIN, 2, free TX slots at or below which io_buffer_full asserts (covers writes already in flight)

Ports:
clk_in  in  1  system clock
rst_in  in  1  reset, asynchronous, active-low
rdy_in  in  1  core ready; bus ignored when low
cpu_a  in  32  core address bus (mem_a)
cpu_dout  in  8  core write data (mem_dout)
cpu_wr  in  1  core write strobe (mem_wr, 1 = write)
cpu_din  out  8  I/O read data, valid the cycle after the read
io_sel  out  1  cpu_din carries I/O data this cycle (top-level mux select)
io_buffer_full  out  1  TX FIFO near full
tx_valid  out  1  byte available to UART transmitter
tx_data  out  8  byte to transmit
tx_ready  in  1  UART transmitter accepts byte
rx_valid  in  1  UART receiver has a byte
rx_data  in  8  received byte
rx_ready  out  1  RX FIFO can accept
program_stop  out  1  one-cycle pulse when the stop terminator has been transmitted
tx_overflow  out  1  sticky: a TX write was dropped because the FIFO was full

Behaviour:
- Reset (rst_in=0, async): FIFOs empty, counter=0, snapshot=0, stopped=0, cpu_din=0, io_sel=0, program_stop=0, tx_overflow=0, tx_valid=0, rx_ready=1, io_buffer_full=0.
- hit = rdy_in & cpu_a[17:16]==2'b11; offset = cpu_a[2:0]; all other address bits ignored.
- Write, offset 0: if cpu_dout!=0 and !stopped, push to TX; cpu_dout==0 ignored.
- Write, offset 4: if !stopped, push 0x00 to TX, set stopped, mark that entry as terminator. All later writes are ignored.
- Push when full and no same-cycle pop: drop the byte, set tx_overflow. Push and pop in the same cycle while full succeeds.
- Read, offset 0: next cycle cpu_din=RX head and pop. If RX is empty, cpu_din=0x00 and no pop.
- Read, offset 4: latch snapshot<=counter, next cycle cpu_din=counter[7:0].
- Read, offsets 5/6/7: next cycle cpu_din=snapshot byte 1/2/3. This gives the core a coherent 32-bit value.
- io_sel=1 exactly one cycle after every I/O read hit, else 0. cpu_din holds its last value when io_sel=0.
- Counter: 32-bit, +1 every clk_in regardless of rdy_in, wraps 0xFFFFFFFF->0.
- TX: tx_valid=!tx_empty, tx_data=head, pop on tx_valid&tx_ready.
- When the terminator pops: program_stop pulses 1 the following cycle.
- RX: rx_ready=!rx_full. Push on rx_valid&rx_ready. Pop and push in the same cycle are both honoured.
- io_buffer_full = (TX_DEPTH - tx_count) <= FULL_MARGIN, combinational from the registered count.
- rdy_in low: no bus decode; FIFO drain/fill and the counter continue.
- Reset mid-operation discards all FIFO contents and pending reads.

Decomposition:
- Package io_port_pkg holds:
  - IO_BASE_SEL (2'b11), OFF_UART (3'd0), OFF_CLK (3'd4)
  - byte and counter widths
  - FIFO entry typedef {terminator bit, 8-bit data}
- One sub-module, io_sync_fifo (parameterised width/depth, count output, async active-low reset), instantiated for TX and RX.

Test Plan:
- Write 0x41,0x42 to 0x30000 with tx_ready=1 -> tx_data 0x41 then 0x42 on consecutive tx handshakes; write 0x00 -> nothing pushed.
- tx_ready=0, 14 writes to 0x30000 -> io_buffer_full=1 after the 14th. 3 more writes -> 2 accepted, 17th dropped, tx_overflow=1.
- rx_valid pushes 0x55 then 0x66 -> reads of 0x30000 return 0x55, 0x66 (io_sel=1 next cycle), then 0x00 when empty.
- At counter=0x000001FF, read 0x30004..0x30007 on successive cycles -> bytes 0xFF,0x01,0x00,0x00 despite the counter advancing.
- Write 0x30004 with 2 bytes queued -> tx emits both then 0x00, program_stop pulses once the cycle after the 0x00 handshake; a later write to 0x30000 is ignored.
- Assert rst_in=0 mid-transfer with TX non-empty -> tx_valid=0, io_buffer_full=0, counter=0 immediately, independent of clk_in.
